// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width defaults and the round-robin pick
// function used by the register-file read arbiter.
package cpu_pkg;

    // Datapath defaults shared by blocks that touch the register file.
    localparam int DATA_W_DEF = 64;
    localparam int REG_W_DEF  = 5;

    // The pick function works on a fixed maximum width; callers zero-extend.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic               valid;
        logic [MAX_REQ-1:0] onehot;
        logic [IDX_W-1:0]   idx;
    } rr_pick_t;

    // First set request at or after ptr, searching upward and wrapping at n-1.
    // Requires ptr < n and n <= MAX_REQ; bits of req at or above n are ignored.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        rr_pick_t r;
        int       cand;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if ((k < n) && !r.valid) begin
                cand = int'(ptr) + k;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (req[cand]) begin
                    r.valid        = 1'b1;
                    r.idx          = cand[IDX_W-1:0];
                    r.onehot[cand] = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-and-priority search: grants the first asserted request
// at or after the pointer. Purely combinational; the pointer lives in the caller.
module rr_picker
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               gnt_valid,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [IDX_W-1:0]   ptr_ext;
    rr_pick_t           pick;
    logic               unused_pick_bits;

    // Widen to the package's fixed width, run the search, narrow the result.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        ptr_ext                = '0;
        ptr_ext[PTR_W-1:0]     = ptr;
        pick                   = rr_pick(req_ext, ptr_ext, NUM_REQ);
        gnt_valid              = pick.valid;
        gnt                    = pick.onehot[NUM_REQ-1:0];
        gnt_idx                = pick.idx[PTR_W-1:0];
    end

    // Upper pick bits are always zero for NUM_REQ < MAX_REQ.
    assign unused_pick_bits = ^pick;

endmodule

// File: rtl/rf_read_arbiter.sv
// Register-file read-port arbiter: one reservation station per cycle gets
// both read ports, operands return one cycle later on a shared bus.
// Optional feature: define RF_ARB_WRITE_BYPASS_EN to forward same-cycle
// register-file writes into the returned operands.
module rf_read_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REG_W   = REG_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][REG_W-1:0]   req_addr1,
    input  logic [NUM_REQ-1:0][REG_W-1:0]   req_addr2,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [REG_W-1:0]                read1,
    output logic [REG_W-1:0]                read2,
    output logic                            read1_enable,
    output logic                            read2_enable,
    input  logic [DATA_W-1:0]               read1_value,
    input  logic [DATA_W-1:0]               read2_value,
    input  logic [REG_W-1:0]                write1,
    input  logic [REG_W-1:0]                write2,
    input  logic                            write1_enable,
    input  logic                            write2_enable,
    input  logic [DATA_W-1:0]               write1_value,
    input  logic [DATA_W-1:0]               write2_value,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [DATA_W-1:0]               resp_op1,
    output logic [DATA_W-1:0]               resp_op2
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Round-robin pointer and the response captured at grant time.
    logic [PTR_W-1:0]  ptr_q,       ptr_d;
    logic              resp_pend_q, resp_pend_d;
    logic [PTR_W-1:0]  resp_idx_q,  resp_idx_d;
    logic [DATA_W-1:0] resp_op1_q,  resp_op1_d;
    logic [DATA_W-1:0] resp_op2_q,  resp_op2_d;

    // Grant search results.
    logic              gnt_valid;
    logic [PTR_W-1:0]  gnt_idx;

    // One-hot masked addresses, OR-reduced into the read ports.
    logic [NUM_REQ-1:0][REG_W-1:0] addr1_masked;
    logic [NUM_REQ-1:0][REG_W-1:0] addr2_masked;

    // Operand values presented during a response cycle.
    logic [DATA_W-1:0] op1_live;
    logic [DATA_W-1:0] op2_live;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr1_masked[gi] = req_addr1[gi] & {REG_W{gnt[gi]}};
            assign addr2_masked[gi] = req_addr2[gi] & {REG_W{gnt[gi]}};
            assign resp_valid[gi]   = resp_pend_q & (resp_idx_q == PTR_W'(gi));
        end
    endgenerate

    // Drive the read ports from the granted requester; zero when idle.
    always_comb begin
        read1 = '0;
        read2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            read1 = read1 | addr1_masked[i];
            read2 = read2 | addr2_masked[i];
        end
        read1_enable = gnt_valid;
        read2_enable = gnt_valid;
    end

`ifdef RF_ARB_WRITE_BYPASS_EN
    // Bypass state captured in the grant cycle, consumed in the response cycle.
    logic              byp1_hit_q, byp1_hit_d;
    logic              byp2_hit_q, byp2_hit_d;
    logic [DATA_W-1:0] byp1_val_q, byp1_val_d;
    logic [DATA_W-1:0] byp2_val_q, byp2_val_d;

    // Match the snooped writes against the granted read addresses; port 2 is
    // the younger write, so it wins when both target the same register.
    always_comb begin
        byp1_hit_d = 1'b0;
        byp2_hit_d = 1'b0;
        byp1_val_d = '0;
        byp2_val_d = '0;
        if (gnt_valid) begin
            if (write2_enable && (write2 == read1)) begin
                byp1_hit_d = 1'b1;
                byp1_val_d = write2_value;
            end else if (write1_enable && (write1 == read1)) begin
                byp1_hit_d = 1'b1;
                byp1_val_d = write1_value;
            end
            if (write2_enable && (write2 == read2)) begin
                byp2_hit_d = 1'b1;
                byp2_val_d = write2_value;
            end else if (write1_enable && (write1 == read2)) begin
                byp2_hit_d = 1'b1;
                byp2_val_d = write1_value;
            end
        end
    end

    // Bypass registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp1_hit_q <= 1'b0;
            byp2_hit_q <= 1'b0;
            byp1_val_q <= '0;
            byp2_val_q <= '0;
        end else begin
            byp1_hit_q <= byp1_hit_d;
            byp2_hit_q <= byp2_hit_d;
            byp1_val_q <= byp1_val_d;
            byp2_val_q <= byp2_val_d;
        end
    end

    // Forwarded write data replaces the stale register-file read.
    always_comb begin
        op1_live = byp1_hit_q ? byp1_val_q : read1_value;
        op2_live = byp2_hit_q ? byp2_val_q : read2_value;
    end
`else
    logic unused_snoop;

    // Without bypass the register-file data is returned untouched.
    always_comb begin
        op1_live = read1_value;
        op2_live = read2_value;
    end

    assign unused_snoop = ^{write1, write2, write1_enable, write2_enable,
                            write1_value, write2_value};
`endif

    // Response bus: live data in the response cycle, otherwise the last value.
    always_comb begin
        resp_op1 = resp_pend_q ? op1_live : resp_op1_q;
        resp_op2 = resp_pend_q ? op2_live : resp_op2_q;
    end

    // Next-state: advance the pointer past a grant, capture the response slot.
    always_comb begin
        ptr_d       = ptr_q;
        resp_pend_d = gnt_valid;
        resp_idx_d  = gnt_idx;
        resp_op1_d  = resp_op1;
        resp_op2_d  = resp_op2;
        if (gnt_valid) begin
            if (gnt_idx == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + PTR_W'(1);
            end
        end
    end

    // Arbiter state; reset drops any response still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            resp_pend_q <= 1'b0;
            resp_idx_q  <= '0;
            resp_op1_q  <= '0;
            resp_op2_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            resp_pend_q <= resp_pend_d;
            resp_idx_q  <= resp_idx_d;
            resp_op1_q  <= resp_op1_d;
            resp_op2_q  <= resp_op2_d;
        end
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter with a small register-file model that
// returns read data one cycle after the strobe.
module tb_rf_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 64;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0][REG_W-1:0] req_addr1;
    logic [NUM_REQ-1:0][REG_W-1:0] req_addr2;
    logic [NUM_REQ-1:0]            gnt;
    logic [REG_W-1:0]              read1, read2;
    logic                          read1_enable, read2_enable;
    logic [DATA_W-1:0]             read1_value, read2_value;
    logic [REG_W-1:0]              write1, write2;
    logic                          write1_enable, write2_enable;
    logic [DATA_W-1:0]             write1_value, write2_value;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_W-1:0]             resp_op1, resp_op2;

    logic [DATA_W-1:0] rf [32];

    int checks;
    int errors;

    rf_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REG_W   (REG_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_addr1     (req_addr1),
        .req_addr2     (req_addr2),
        .gnt           (gnt),
        .read1         (read1),
        .read2         (read2),
        .read1_enable  (read1_enable),
        .read2_enable  (read2_enable),
        .read1_value   (read1_value),
        .read2_value   (read2_value),
        .write1        (write1),
        .write2        (write2),
        .write1_enable (write1_enable),
        .write2_enable (write2_enable),
        .write1_value  (write1_value),
        .write2_value  (write2_value),
        .resp_valid    (resp_valid),
        .resp_op1      (resp_op1),
        .resp_op2      (resp_op2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: registered reads, write port 2 applied last.
    always @(posedge clk) begin
        if (read1_enable) read1_value <= rf[read1];
        if (read2_enable) read2_value <= rf[read2];
        if (write1_enable) rf[write1] <= write1_value;
        if (write2_enable) rf[write2] <= write2_value;
    end

    task automatic set_addrs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr1[i] = REG_W'(8 + i);
            req_addr2[i] = REG_W'(16 + i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt got %b want %b", gnt, 4'b0000);
        end
        checks++;
        if (read1_enable !== 1'b0 || read2_enable !== 1'b0) begin
            errors++; $display("FAIL reset_enables got %b%b want 00", read1_enable, read2_enable);
        end
        checks++;
        if (resp_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_resp_valid got %b want %b", resp_valid, 4'b0000);
        end
        checks++;
        if (resp_op1 !== 64'd0 || resp_op2 !== 64'd0) begin
            errors++; $display("FAIL reset_resp_ops got %h/%h want 0/0", resp_op1, resp_op2);
        end
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] exp1, exp2;
        @(negedge clk);
        req_addr1[0] = 5'd3;
        req_addr2[0] = 5'd7;
        req = 4'b0001;
        exp1 = rf[3];
        exp2 = rf[7];
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL single_gnt got %b want %b", gnt, 4'b0001);
        end
        checks++;
        if (read1 !== 5'd3 || read2 !== 5'd7) begin
            errors++; $display("FAIL single_addr got %0d/%0d want 3/7", read1, read2);
        end
        checks++;
        if (read1_enable !== 1'b1 || read2_enable !== 1'b1) begin
            errors++; $display("FAIL single_enables got %b%b want 11", read1_enable, read2_enable);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 4'b0001) begin
            errors++; $display("FAIL single_resp_valid got %b want %b", resp_valid, 4'b0001);
        end
        checks++;
        if (resp_op1 !== exp1 || resp_op2 !== exp2) begin
            errors++; $display("FAIL single_resp_ops got %h/%h want %h/%h", resp_op1, resp_op2, exp1, exp2);
        end
        $display("txn single gnt=%b op1=%h op2=%h", 4'b0001, resp_op1, resp_op2);
        // Pointer must now sit at 1: with everyone requesting, 1 wins.
        set_addrs();
        @(negedge clk);
        req = 4'b1111;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL single_ptr_next got %b want %b", gnt, 4'b0010);
        end
        @(posedge clk);
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_hold_idle();
        // Last response delivered was requester 1 (addr 9 / 17).
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 4'b0000) begin
            errors++; $display("FAIL idle_resp_valid got %b want %b", resp_valid, 4'b0000);
        end
        checks++;
        if (resp_op1 !== rf[9] || resp_op2 !== rf[17]) begin
            errors++; $display("FAIL idle_hold got %h/%h want %h/%h", resp_op1, resp_op2, rf[9], rf[17]);
        end
    endtask

    task automatic test_wrap();
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        logic [NUM_REQ-1:0] exp_gnt;
        do_reset();
        set_addrs();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req = 4'b1111;
            exp_gnt = 4'b0001 << exp_idx[k];
            #1;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++; $display("FAIL wrap_gnt[%0d] got %b want %b", k, gnt, exp_gnt);
            end
            @(posedge clk);
            #1;
            checks++;
            if (resp_valid !== exp_gnt || resp_op1 !== rf[8 + exp_idx[k]]) begin
                errors++; $display("FAIL wrap_resp[%0d] got %b/%h want %b/%h", k, resp_valid, resp_op1, exp_gnt, rf[8 + exp_idx[k]]);
            end
            $display("txn wrap k=%0d gnt=%b", k, exp_gnt);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_ptr3();
        do_reset();
        set_addrs();
        @(negedge clk);
        req = 4'b0100;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL ptr3_setup got %b want %b", gnt, 4'b0100);
        end
        @(posedge clk);
        @(negedge clk);
        req = 4'b0101;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL ptr3_first got %b want %b", gnt, 4'b0001);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL ptr3_second got %b want %b", gnt, 4'b0100);
        end
        $display("txn ptr3 gnt 0001 then 0100");
        @(posedge clk);
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] old5, old6, exp1, exp2;
        do_reset();
        set_addrs();
        req_addr1[0] = 5'd5;
        req_addr2[0] = 5'd6;
        old5 = rf[5];
        old6 = rf[6];
`ifdef RF_ARB_WRITE_BYPASS_EN
        exp1 = 64'hBB;
        exp2 = old6;
`else
        exp1 = old5;
        exp2 = old6;
`endif
        @(negedge clk);
        req = 4'b0001;
        write1 = 5'd5; write1_enable = 1'b1; write1_value = 64'hAA;
        write2 = 5'd5; write2_enable = 1'b1; write2_value = 64'hBB;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL bypass_gnt got %b want %b", gnt, 4'b0001);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_op1 !== exp1) begin
            errors++; $display("FAIL bypass_op1 got %h want %h", resp_op1, exp1);
        end
        checks++;
        if (resp_op2 !== exp2) begin
            errors++; $display("FAIL bypass_op2_nomatch got %h want %h", resp_op2, exp2);
        end
        // Single-port match on the second read address.
        @(negedge clk);
        req = 4'b0000;
        write2_enable = 1'b0;
        write1 = 5'd6; write1_enable = 1'b1; write1_value = 64'h5A;
        @(posedge clk);
        @(negedge clk);
        write1 = 5'd6; write1_enable = 1'b1; write1_value = 64'h77;
        req = 4'b0001;
        old6 = rf[6];
`ifdef RF_ARB_WRITE_BYPASS_EN
        exp2 = 64'h77;
`else
        exp2 = old6;
`endif
        @(posedge clk);
        #1;
        checks++;
        if (resp_op2 !== exp2) begin
            errors++; $display("FAIL bypass_op2_port1 got %h want %h", resp_op2, exp2);
        end
        $display("txn bypass op1=%h op2=%h", exp1, exp2);
        @(negedge clk);
        req = '0;
        write1_enable = 1'b0;
        write2_enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_addrs();
        @(negedge clk);
        req = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL rstmid_gnt got %b want %b", gnt, 4'b0010);
        end
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 4'b0000) begin
            errors++; $display("FAIL rstmid_in_reset got %b want %b", resp_valid, 4'b0000);
        end
        @(negedge clk);
        req = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 4'b0000) begin
            errors++; $display("FAIL rstmid_after_release got %b want %b", resp_valid, 4'b0000);
        end
        // Pointer restarted at 0: requester 1 beats requester 2.
        @(negedge clk);
        req = 4'b0110;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL rstmid_next_gnt got %b want %b", gnt, 4'b0010);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 4'b0010) begin
            errors++; $display("FAIL rstmid_next_resp got %b want %b", resp_valid, 4'b0010);
        end
        $display("txn reset_mid next gnt=%b", 4'b0010);
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_reset_async();
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk);
        #1;
        req = '0;
        checks++;
        if (resp_valid !== 4'b0001) begin
            errors++; $display("FAIL async_pre got %b want %b", resp_valid, 4'b0001);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 4'b0000 || resp_op1 !== 64'd0 || resp_op2 !== 64'd0) begin
            errors++; $display("FAIL async_clear got %b/%h/%h want 0000/0/0", resp_valid, resp_op1, resp_op2);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("txn async reset cleared response");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        req           = '0;
        write1        = '0;
        write2        = '0;
        write1_enable = 1'b0;
        write2_enable = 1'b0;
        write1_value  = '0;
        write2_value  = '0;
        read1_value   = '0;
        read2_value   = '0;
        set_addrs();
        for (int i = 0; i < 32; i++) begin
            rf[i] = 64'h0101_0101_0101_0101 * 64'(i) + 64'h1000;
        end
        @(posedge clk);
        @(posedge clk);
        test_reset();
        test_single();
        test_hold_idle();
        test_wrap();
        test_ptr3();
        test_bypass();
        test_reset_mid();
        test_reset_async();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_read_arbiter.md
RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesting reservation stations (2..8).
REQ-002 SHALL have parameter REG_W, default 5, giving the register address width.
REQ-003 SHALL have parameter DATA_W, default 64, giving the register data width.
REQ-004 SHALL have port clk  input  1  as the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  as the asynchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  as the per-requester operand-read request, held until granted.
REQ-007 SHALL have port req_addr1 / req_addr2  input  NUM_REQ x REG_W  as the per-requester source register addresses.
REQ-008 SHALL have port gnt  output  NUM_REQ  as the one-hot (or zero) grant, valid in the request cycle.
REQ-009 SHALL have port read1 / read2  output  REG_W  as the register file read addresses.
REQ-010 SHALL have port read1_enable / read2_enable  output  1  as the register file read strobes.
REQ-011 SHALL have port read1_value / read2_value  input  DATA_W  as the register file read data, returned one cycle after the strobe.
REQ-012 SHALL have port write1 / write2  input  REG_W, write1_enable / write2_enable  input  1, and write1_value / write2_value  input  DATA_W  as a snoop of both register file write ports.
REQ-013 SHALL have port resp_valid  output  NUM_REQ  as the one-hot operand-return strobe.
REQ-014 SHALL have port resp_op1 / resp_op2  output  DATA_W  as the shared operand-return bus.

Function
REQ-015 SHALL grant, combinationally in cycle T, the first asserted req at or after rotating pointer ptr, searching upward and wrapping at NUM_REQ-1.
REQ-016 SHALL drive gnt to all zero, and read1_enable and read2_enable to 0, when no req is asserted.
REQ-017 SHALL drive read1 and read2 from the granted requester's req_addr1 and req_addr2, with both enables set to 1, in cycle T.
REQ-018 SHALL load ptr with (granted index + 1) mod NUM_REQ at the end of any cycle with a grant, and hold ptr otherwise.
REQ-019 SHALL assert resp_valid[i] in cycle T+1 only, carrying read1_value and read2_value on resp_op1 and resp_op2; fixed latency is 1.
REQ-020 SHALL accept one grant per cycle, so back-to-back grants produce back-to-back responses with no bubble.
REQ-021 SHALL hold resp_op1 and resp_op2 at their last value while resp_valid is all zero.
REQ-022 SHALL leave a requester that is still asserting req after its grant cycle eligible again, subject only to round-robin order.

Reset
REQ-023 SHALL, while rst is high and regardless of clk, force ptr=0, resp_valid=0, resp_op1=0, resp_op2=0, and the captured response index and bypass state to 0.
REQ-024 SHALL discard a response pending at reset assertion, never presenting it after reset release.
REQ-025 SHALL permit a grant in the first clk edge after rst deasserts.

Configuration
REQ-026 SHALL, when macro RF_ARB_WRITE_BYPASS_EN is defined, register in cycle T a match of write1 or write2 (with its enable set) against the granted read1 or read2 address, and return the matching write value on the corresponding resp_op in T+1 instead of the register file value.
REQ-027 SHALL, when both write ports match the same read address in cycle T with bypass enabled, forward write2_value.
REQ-028 SHALL, when RF_ARB_WRITE_BYPASS_EN is undefined, return the raw register file read data with no snoop logic, leaving the write snoop ports unused.

Structure
REQ-029 SHALL place the round-robin pick function (request vector plus pointer giving one-hot plus index) and the DATA_W/REG_W defaults in shared package cpu_pkg.
REQ-030 SHALL use a sub-module rr_picker for the combinational rotate-and-priority search, and keep all state in rf_read_arbiter.

Verification
REQ-031 SHALL cover: after reset, req=4'b0001 with addr1=3 and addr2=7 -> gnt=0001, read1=3, read2=7 in T; resp_valid=0001 with register values in T+1; ptr=1.
REQ-032 SHALL cover: req=4'b1111 held 4 cycles from ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, then 0001 again (wrap).
REQ-033 SHALL cover: ptr=3 and req=4'b0101 -> gnt=0001, then next cycle gnt=0100.
REQ-034 SHALL cover, with bypass enabled: grant addr1=5 while write1_enable=1, write1=5, write1_value=0xAA, and write2_enable=1, write2=5, write2_value=0xBB -> resp_op1=0xBB in T+1; the same stimulus with bypass disabled -> resp_op1 equals the old register 5 contents.
REQ-035 SHALL cover: rst asserted mid-cycle between a grant and its response -> resp_valid stays 0 after release, and the next req=4'b0010 is granted with ptr restarting at 0.
